interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer_pkg.sv | 24 ++
 rtl/interrupt_sequencer_edge_detect.sv | 25 ++
 rtl/interrupt_sequencer.sv | 148 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings and default handler vectors for the interrupt sequencer.
package interrupt_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_SVC  = 2'd3
    } state_t;

    typedef enum logic {
        SRC_INT = 1'b0,
        SRC_NMI = 1'b1
    } src_t;

    localparam logic [31:0] DEF_INT_VEC = 32'h0000_0080;
    localparam logic [31:0] DEF_NMI_VEC = 32'h0000_0100;

    function automatic logic [31:0] src_vec(input src_t src, input logic [31:0] int_vec,
                                            input logic [31:0] nmi_vec);
        return (src == SRC_NMI) ? nmi_vec : int_vec;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_edge_detect.sv
// Rising-edge detector. A level already high when reset releases is not an edge:
// the detector only arms after it has seen the input low once.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_armed <= r_armed | ~i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev & r_armed;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates maskable INT and edge-triggered NMI, hands the
// controller a vector at an instruction boundary, and tracks one level of NMI-over-INT nesting.
//
// state | meaning
// IDLE  | nothing requested or in service
// REQ   | isInterrupted raised, waiting for instr_boundary
// ACK   | one-cycle INA pulse
// SVC   | handler running (nested when an INT handler is saved underneath)
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [31:0] INT_VEC = DEF_INT_VEC,
    parameter logic [31:0] NMI_VEC = DEF_NMI_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        NMI,
    input  logic        INTD,
    input  logic        instr_boundary,
    input  logic        eret,
    output logic        isInterrupted,
    output logic [31:0] irq_vec,
    output logic        INA,
    output logic        in_service,
    output logic        nested,
    output logic        eret_err
);

    state_t r_state;
    state_t w_state_nxt;
    src_t   r_src;
    src_t   w_src_nxt;
    logic   r_saved_valid;
    logic   w_saved_valid_nxt;
    logic   r_nmi_pend;
    logic   r_eret_err;
    logic   w_nmi_rise;
    logic   w_nmi_any;
    logic   w_nmi_clr;
    logic   w_eret_err_set;
    logic   w_handler_active;
    logic   w_int_ok;

    edge_detect u_nmi_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (NMI),
        .o_rise (w_nmi_rise)
    );

    // A fresh edge counts immediately so NMI beats a simultaneous INT.
    assign w_nmi_any        = r_nmi_pend | w_nmi_rise;
    assign w_handler_active = (r_state == ST_ACK) || (r_state == ST_SVC) || r_saved_valid;
    assign w_int_ok         = INT & ~INTD & ~w_handler_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_src         <= SRC_INT;
            r_saved_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_src         <= w_src_nxt;
            r_saved_valid <= w_saved_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_src_nxt         = r_src;
        w_saved_valid_nxt = r_saved_valid;
        w_nmi_clr         = 1'b0;
        w_eret_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_eret_err_set = eret;
                if (w_nmi_any) begin
                    w_state_nxt = ST_REQ;
                    w_src_nxt   = SRC_NMI;
                end else if (w_int_ok) begin
                    w_state_nxt = ST_REQ;
                    w_src_nxt   = SRC_INT;
                end
            end
            ST_REQ: begin
                w_eret_err_set = eret & ~r_saved_valid;
                if (r_src == SRC_INT) begin
                    if (w_nmi_any) begin
                        w_src_nxt = SRC_NMI;
                    end else if (!INT || INTD) begin
                        w_state_nxt = ST_IDLE;
                    end else if (instr_boundary) begin
                        w_state_nxt = ST_ACK;
                    end
                end else if (instr_boundary) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_nmi_clr   = (r_src == SRC_NMI);
                w_state_nxt = ST_SVC;
            end
            ST_SVC: begin
                if (eret) begin
                    if (r_saved_valid) begin
                        w_src_nxt         = SRC_INT;
                        w_saved_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if ((r_src == SRC_INT) && w_nmi_any) begin
                    w_saved_valid_nxt = 1'b1;
                    w_src_nxt         = SRC_NMI;
                    w_state_nxt       = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A new edge during the ACK of an earlier NMI must survive the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nmi_pend <= 1'b0;
        end else if (w_nmi_rise) begin
            r_nmi_pend <= 1'b1;
        end else if (w_nmi_clr) begin
            r_nmi_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eret_err <= 1'b0;
        end else if (w_eret_err_set) begin
            r_eret_err <= 1'b1;
        end
    end

    assign isInterrupted = (r_state == ST_REQ);
    assign INA           = (r_state == ST_ACK);
    assign in_service    = (r_state == ST_SVC);
    assign nested        = (r_state == ST_SVC) && r_saved_valid;
    assign irq_vec       = (r_state == ST_IDLE) ? 32'h0 : src_vec(r_src, INT_VEC, NMI_VEC);
    assign eret_err      = r_eret_err;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: stimulus pushes expected INA vectors into a
// queue, a negedge monitor pops and compares them on every acknowledge pulse.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        NMI;
    logic        INTD;
    logic        instr_boundary;
    logic        eret;
    logic        isInterrupted;
    logic [31:0] irq_vec;
    logic        INA;
    logic        in_service;
    logic        nested;
    logic        eret_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic        prev_ina = 1'b0;

    localparam logic [31:0] V_INT = 32'h0000_0080;
    localparam logic [31:0] V_NMI = 32'h0000_0100;

    interrupt_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .INT            (INT),
        .NMI            (NMI),
        .INTD           (INTD),
        .instr_boundary (instr_boundary),
        .eret           (eret),
        .isInterrupted  (isInterrupted),
        .irq_vec        (irq_vec),
        .INA            (INA),
        .in_service     (in_service),
        .nested         (nested),
        .eret_err       (eret_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_isint"}, {31'b0, isInterrupted}, 32'd0);
        chk({tag, "_ina"},   {31'b0, INA}, 32'd0);
        chk({tag, "_svc"},   {31'b0, in_service}, 32'd0);
        chk({tag, "_nest"},  {31'b0, nested}, 32'd0);
        chk({tag, "_err"},   {31'b0, eret_err}, 32'd0);
        chk({tag, "_vec"},   irq_vec, 32'd0);
    endtask

    // Scoreboard monitor: every INA pulse must match the oldest expected vector.
    initial begin
        forever begin
            @(negedge clk);
            if (INA === 1'b1) begin
                chk("ina_single_cycle", {31'b0, prev_ina}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ina_unexpected: irq_vec=%h with nothing expected at %0t", irq_vec, $time);
                end else begin
                    chk("ina_vec", irq_vec, exp_q.pop_front());
                    chk("ina_isint_low", {31'b0, isInterrupted}, 32'd0);
                end
            end
            prev_ina = (INA === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; INT = 1'b0; NMI = 1'b0; INTD = 1'b0; instr_boundary = 1'b0; eret = 1'b0;
        cyc(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc(1);

        // Plain INT request, boundary after a few cycles; INT held high through service.
        INT = 1'b1;
        cyc(1);
        chk("t1_isint", {31'b0, isInterrupted}, 32'd1);
        chk("t1_vec", irq_vec, V_INT);
        exp_q.push_back(V_INT);
        cyc(3);
        chk("t1_wait_isint", {31'b0, isInterrupted}, 32'd1);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0;
        chk("t1_ina", {31'b0, INA}, 32'd1);
        cyc(1);
        chk("t1_svc", {31'b0, in_service}, 32'd1);
        chk("t1_svc_vec", irq_vec, V_INT);
        chk("t1_ina_drop", {31'b0, INA}, 32'd0);
        cyc(3);
        chk("t1_no_rereq", {31'b0, isInterrupted}, 32'd0);
        INT = 1'b0; eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("t1_idle_svc", {31'b0, in_service}, 32'd0);
        chk("t1_idle_vec", irq_vec, 32'd0);
        chk("t1_no_err", {31'b0, eret_err}, 32'd0);

        // INT and NMI edge together: NMI first, INT after eret.
        INT = 1'b1; NMI = 1'b1;
        cyc(1);
        NMI = 1'b0;
        chk("t2_vec_nmi", irq_vec, V_NMI);
        chk("t2_isint", {31'b0, isInterrupted}, 32'd1);
        exp_q.push_back(V_NMI);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0;
        cyc(1);
        chk("t2_svc_vec", irq_vec, V_NMI);
        chk("t2_nested", {31'b0, nested}, 32'd0);
        exp_q.push_back(V_INT);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("t2_idle", {31'b0, isInterrupted}, 32'd0);
        cyc(1);
        chk("t2_int_req", {31'b0, isInterrupted}, 32'd1);
        chk("t2_int_vec", irq_vec, V_INT);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0; INT = 1'b0;
        cyc(1);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;

        // INTD raised before boundary withdraws the request; masked INT stays quiet.
        INT = 1'b1;
        cyc(1);
        chk("t3_isint", {31'b0, isInterrupted}, 32'd1);
        INTD = 1'b1;
        cyc(1);
        chk("t3_withdrawn", {31'b0, isInterrupted}, 32'd0);
        chk("t3_vec_zero", irq_vec, 32'd0);
        instr_boundary = 1'b1;
        cyc(2);
        chk("t3_masked", {31'b0, isInterrupted}, 32'd0);
        chk("t3_no_svc", {31'b0, in_service}, 32'd0);
        INT = 1'b0; INTD = 1'b0; instr_boundary = 1'b0;
        cyc(1);

        // NMI preempts INT handler; NMI during NMI handler waits; two-level unwind.
        INT = 1'b1;
        exp_q.push_back(V_INT);
        cyc(1);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0; INT = 1'b0;
        cyc(1);
        chk("t4_svc_int", {31'b0, in_service}, 32'd1);
        chk("t4_not_nested", {31'b0, nested}, 32'd0);
        NMI = 1'b1;
        exp_q.push_back(V_NMI);
        cyc(1);
        NMI = 1'b0;
        chk("t4_preempt_req", {31'b0, isInterrupted}, 32'd1);
        chk("t4_preempt_vec", irq_vec, V_NMI);
        chk("t4_nested_before_ack", {31'b0, nested}, 32'd0);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0;
        cyc(1);
        chk("t4_nested", {31'b0, nested}, 32'd1);
        chk("t4_nmi_svc_vec", irq_vec, V_NMI);
        NMI = 1'b1;
        cyc(1);
        NMI = 1'b0;
        cyc(1);
        chk("t4_no_nmi_nest", {31'b0, isInterrupted}, 32'd0);
        chk("t4_still_nested", {31'b0, nested}, 32'd1);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("t4_unnest", {31'b0, nested}, 32'd0);
        chk("t4_back_in_int", {31'b0, in_service}, 32'd1);
        chk("t4_back_vec", irq_vec, V_INT);
        exp_q.push_back(V_NMI);
        cyc(1);
        chk("t4_pend_nmi_req", {31'b0, isInterrupted}, 32'd1);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0;
        cyc(1);
        chk("t4_nested2", {31'b0, nested}, 32'd1);
        eret = 1'b1;
        cyc(1);
        chk("t4_unnest2", {31'b0, nested}, 32'd0);
        chk("t4_svc2", {31'b0, in_service}, 32'd1);
        cyc(1);
        eret = 1'b0;
        chk("t4_idle", {31'b0, in_service}, 32'd0);
        chk("t4_idle_vec", irq_vec, 32'd0);
        chk("t4_no_err", {31'b0, eret_err}, 32'd0);

        // Stray eret sets sticky error; reset in SVC clears everything.
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("t5_err_set", {31'b0, eret_err}, 32'd1);
        cyc(3);
        chk("t5_err_sticky", {31'b0, eret_err}, 32'd1);
        INT = 1'b1;
        exp_q.push_back(V_INT);
        cyc(1);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0; INT = 1'b0;
        cyc(1);
        chk("t5_svc", {31'b0, in_service}, 32'd1);
        rst_n = 1'b0; NMI = 1'b1;
        cyc(1);
        chk_all_zero("t5_rst");
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        chk("t5_nmi_held_no_edge", {31'b0, isInterrupted}, 32'd0);
        NMI = 1'b0;
        cyc(1);
        chk("t5_nmi_fall", {31'b0, isInterrupted}, 32'd0);

        // Reset while requesting aborts without INA.
        INT = 1'b1;
        cyc(1);
        chk("t6_req", {31'b0, isInterrupted}, 32'd1);
        rst_n = 1'b0; instr_boundary = 1'b1;
        cyc(1);
        chk("t6_abort_isint", {31'b0, isInterrupted}, 32'd0);
        chk("t6_abort_ina", {31'b0, INA}, 32'd0);
        rst_n = 1'b1; INT = 1'b0; instr_boundary = 1'b0;
        cyc(2);

        // Pending INT request upgraded to NMI before boundary, even as INT drops.
        INT = 1'b1;
        cyc(1);
        chk("t7_int_vec", irq_vec, V_INT);
        NMI = 1'b1; INT = 1'b0;
        exp_q.push_back(V_NMI);
        cyc(1);
        NMI = 1'b0;
        chk("t7_upgrade_req", {31'b0, isInterrupted}, 32'd1);
        chk("t7_upgrade_vec", irq_vec, V_NMI);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0;
        cyc(1);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("t7_idle", {31'b0, in_service}, 32'd0);

        // eret and NMI edge in the same cycle: return honoured, NMI requested next.
        INT = 1'b1;
        exp_q.push_back(V_INT);
        cyc(1);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0; INT = 1'b0;
        cyc(1);
        eret = 1'b1; NMI = 1'b1;
        cyc(1);
        eret = 1'b0; NMI = 1'b0;
        chk("t8_eret_done", {31'b0, in_service}, 32'd0);
        chk("t8_not_yet", {31'b0, isInterrupted}, 32'd0);
        exp_q.push_back(V_NMI);
        cyc(1);
        chk("t8_nmi_req", {31'b0, isInterrupted}, 32'd1);
        chk("t8_nmi_vec", irq_vec, V_NMI);
        instr_boundary = 1'b1;
        cyc(1);
        instr_boundary = 1'b0;
        cyc(1);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("t8_err_clear", {31'b0, eret_err}, 32'd0);

        cyc(3);
        chk("ina_missing", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
